// File: rtl/matrix_gen_kxk.sv
// KSIZE x KSIZE sliding-window generator over a raster pixel stream, with internal line memories.
// Optional matrix_edge output is enabled by defining MATRIX_GEN_EDGE_FLAG_EN.
module matrix_gen_kxk #(
  parameter int KSIZE     = 7,
  parameter int DW        = 1,
  parameter int IMG_HDISP = 640
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        per_frame_vsync,
  input  logic                        per_frame_href,
  input  logic                        per_frame_clken,
  input  logic [DW-1:0]               per_img_data,
  output logic                        matrix_frame_vsync,
  output logic                        matrix_frame_href,
  output logic                        matrix_frame_clken,
`ifdef MATRIX_GEN_EDGE_FLAG_EN
  output logic                        matrix_edge,
`endif
  output logic [KSIZE*KSIZE*DW-1:0]   matrix_data
);

  localparam int NMEM = KSIZE - 1;
  localparam int CW   = $clog2(IMG_HDISP + 1);
  localparam int AW   = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int RW   = $clog2(KSIZE);
  localparam int ROWW = KSIZE * DW;

  // Stream semantics: a pixel is accepted when href && clken; there is no backpressure.
  logic          w_acc, w_href_rise, w_href_fall, w_vs_rise, w_in_img;
  logic [CW-1:0] w_pix_col;
  logic [AW-1:0] w_addr;

  logic          r_vs_d1, r_href_d1, r_ce_d1, r_acc_d1, r_rise_d1;
  logic          r_vs_d2, r_href_d2, r_ce_d2;
  logic [DW-1:0] r_pix_d1;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [KSIZE-2:0] r_row_vis, w_row_vis;

  logic [DW-1:0] r_mem [NMEM][IMG_HDISP];
  logic [DW-1:0] r_tap [NMEM];

  logic [KSIZE*KSIZE*DW-1:0] r_win, w_win_next, r_data;
  logic [ROWW-1:0]           w_row_base;
  logic [DW-1:0]             w_col_new [KSIZE];

  assign w_acc       = per_frame_href & per_frame_clken;
  assign w_href_rise = per_frame_href & ~r_href_d1;
  assign w_href_fall = ~per_frame_href & r_href_d1;
  assign w_vs_rise   = per_frame_vsync & ~r_vs_d1;
  assign w_pix_col   = w_href_rise ? '0 : r_col;
  assign w_in_img    = int'(w_pix_col) < IMG_HDISP;
  assign w_addr      = w_pix_col[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      if (w_href_rise)
        r_col <= w_acc ? CW'(1) : '0;
      else if (w_acc && w_in_img)
        r_col <= r_col + CW'(1);
      // A vsync rise takes priority over an href fall in the same cycle.
      if (w_vs_rise)
        r_row <= '0;
      else if (w_href_fall && r_row != RW'(KSIZE - 1))
        r_row <= r_row + RW'(1);
    end
  end

  always_comb begin
    w_row_vis = '0;
    for (int r = 0; r < KSIZE - 1; r++)
      w_row_vis[r] = w_in_img && (r + int'(r_row) >= KSIZE - 1);
  end

  // Cascade: read-before-write pushes each column one memory deeper.
  always_ff @(posedge clk) begin
    if (w_acc && w_in_img) begin
      r_mem[0][w_addr] <= per_img_data;
      for (int m = 1; m < NMEM; m++)
        r_mem[m][w_addr] <= r_mem[m-1][w_addr];
      for (int m = 0; m < NMEM; m++)
        r_tap[m] <= r_mem[m][w_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_d1   <= 1'b0;
      r_href_d1 <= 1'b0;
      r_ce_d1   <= 1'b0;
      r_acc_d1  <= 1'b0;
      r_rise_d1 <= 1'b0;
      r_pix_d1  <= '0;
      r_row_vis <= '0;
    end else begin
      r_vs_d1   <= per_frame_vsync;
      r_href_d1 <= per_frame_href;
      r_ce_d1   <= per_frame_clken;
      r_acc_d1  <= w_acc;
      r_rise_d1 <= w_href_rise;
      r_pix_d1  <= per_img_data;
      r_row_vis <= w_row_vis;
    end
  end

  always_comb begin
    for (int r = 0; r < KSIZE; r++)
      w_col_new[r] = '0;
    for (int r = 0; r < KSIZE - 1; r++)
      w_col_new[r] = r_row_vis[r] ? r_tap[KSIZE-2-r] : '0;
    w_col_new[KSIZE-1] = r_pix_d1;
  end

  // Element c=KSIZE-1 is the newest pixel, so a spatial left shift moves bits down by DW.
  always_comb begin
    w_win_next = r_win;
    w_row_base = '0;
    for (int r = 0; r < KSIZE; r++) begin
      w_row_base = r_rise_d1 ? '0 : r_win[r*ROWW +: ROWW];
      if (r_acc_d1)
        w_win_next[r*ROWW +: ROWW] = {w_col_new[r], w_row_base[ROWW-1:DW]};
      else
        w_win_next[r*ROWW +: ROWW] = w_row_base;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_d2   <= 1'b0;
      r_href_d2 <= 1'b0;
      r_ce_d2   <= 1'b0;
      r_win     <= '0;
      r_data    <= '0;
    end else begin
      r_vs_d2   <= r_vs_d1;
      r_href_d2 <= r_href_d1;
      r_ce_d2   <= r_ce_d1;
      r_win     <= w_win_next;
      if (r_ce_d1)
        r_data <= w_win_next;
    end
  end

`ifdef MATRIX_GEN_EDGE_FLAG_EN
  logic r_edge_d1, r_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_d1 <= 1'b0;
      r_edge    <= 1'b0;
    end else begin
      r_edge_d1 <= (int'(w_pix_col) < KSIZE - 1) || (int'(r_row) < KSIZE - 1) || !w_in_img;
      if (r_ce_d1)
        r_edge <= r_edge_d1;
    end
  end

  assign matrix_edge = r_edge;
`endif

  assign matrix_frame_vsync = r_vs_d2;
  assign matrix_frame_href  = r_href_d2;
  assign matrix_frame_clken = r_ce_d2;
  assign matrix_data        = r_data;

endmodule
